// File: rtl/counter_chain_ctrl.sv
// Run/pause/step/load/stop sequencer for a two-digit cascaded modulo counter (N fast, M slow)
// with target-match detection. Define AUTO_RELOAD_EN to make a target match reload 0 and keep going.
module counter_chain_ctrl #(
  parameter int N_MOD = 6,
  parameter int M_MOD = 13,
  parameter int N_W   = 3,
  parameter int M_W   = 4
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           start,
  input  logic           stop,
  input  logic           pause,
  input  logic           step,
  input  logic           load,
  input  logic [N_W-1:0] load_n,
  input  logic [M_W-1:0] load_m,
  input  logic [N_W-1:0] target_n,
  input  logic [M_W-1:0] target_m,
  output logic [N_W-1:0] count_n,
  output logic [M_W-1:0] count_m,
  output logic           carry_n,
  output logic           carry_m,
  output logic           busy,
  output logic           done,
  output logic [1:0]     state
);

  // state | meaning
  // IDLE  | stopped, counts held
  // RUN   | one tick per cycle
  // PAUSE | counts held, step gives single ticks
  // DONE  | target reached, counts held
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t         st, st_nx;
  logic [N_W-1:0] cnt_n_nx, tick_n, ld_n;
  logic [M_W-1:0] cnt_m_nx, tick_m, ld_m;
  logic           wrap_n, wrap_m, match, do_tick;
  logic           carry_n_nx, carry_m_nx, busy_nx, done_nx;

  assign state = st;

  // Post-tick digit values; M only moves when N wraps
  assign wrap_n = (count_n == N_W'(N_MOD - 1));
  assign wrap_m = (count_m == M_W'(M_MOD - 1));
  assign tick_n = wrap_n ? '0 : count_n + N_W'(1);
  assign tick_m = !wrap_n ? count_m : (wrap_m ? '0 : count_m + M_W'(1));
  assign match  = (tick_n == target_n) && (tick_m == target_m);

  // Out-of-range load values collapse to 0
  assign ld_n = (int'(load_n) >= N_MOD) ? '0 : load_n;
  assign ld_m = (int'(load_m) >= M_MOD) ? '0 : load_m;

  always_comb begin
    st_nx      = st;
    cnt_n_nx   = count_n;
    cnt_m_nx   = count_m;
    carry_n_nx = 1'b0;
    carry_m_nx = 1'b0;
    done_nx    = 1'b0;
    do_tick    = 1'b0;

    case (st)
      IDLE: begin
        if (stop) begin
          st_nx = IDLE;
        end else if (load) begin
          cnt_n_nx = ld_n;
          cnt_m_nx = ld_m;
          if (start) st_nx = RUN;
        end else if (start) begin
          st_nx = RUN;
        end
      end
      RUN: begin
        if (stop)                st_nx = IDLE;
        else if (pause && !start) st_nx = PAUSE;
        else                     do_tick = 1'b1;
      end
      PAUSE: begin
        if (stop) begin
          st_nx = IDLE;
        end else if (load) begin
          cnt_n_nx = ld_n;
          cnt_m_nx = ld_m;
        end else if (start) begin
          st_nx = RUN;
        end else if (!pause && step) begin
          do_tick = 1'b1;
        end
      end
      DONE: begin
        if (stop) begin
          st_nx = IDLE;
        end else if (load) begin
          cnt_n_nx = ld_n;
          cnt_m_nx = ld_m;
          st_nx    = IDLE;
        end else if (start) begin
          cnt_n_nx = '0;
          cnt_m_nx = '0;
          st_nx    = RUN;
        end
      end
      default: st_nx = IDLE;
    endcase

    if (do_tick) begin
      cnt_n_nx   = tick_n;
      cnt_m_nx   = tick_m;
      carry_n_nx = wrap_n;
      carry_m_nx = wrap_n && wrap_m;
      if (match) begin
`ifdef AUTO_RELOAD_EN
        cnt_n_nx = '0;
        cnt_m_nx = '0;
        done_nx  = 1'b1;
`else
        st_nx    = DONE;
`endif
      end
    end

`ifndef AUTO_RELOAD_EN
    done_nx = (st_nx == DONE);
`endif
    busy_nx = (st_nx == RUN) || (st_nx == PAUSE);
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      st      <= IDLE;
      count_n <= '0;
      count_m <= '0;
      carry_n <= 1'b0;
      carry_m <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      st      <= st_nx;
      count_n <= cnt_n_nx;
      count_m <= cnt_m_nx;
      carry_n <= carry_n_nx;
      carry_m <= carry_m_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_counter_chain_ctrl.sv
// Scenario bench for counter_chain_ctrl (default build, N_MOD=6, M_MOD=13): each task builds a
// stimulus plan with expected outputs; drive() queues the expectation, the task pops and compares.
module tb_counter_chain_ctrl;

  logic       clk;
  logic       Reset, start, stop, pause, step, load;
  logic [2:0] load_n, target_n, count_n;
  logic [3:0] load_m, target_m, count_m;
  logic       carry_n, carry_m, busy, done;
  logic [1:0] state;

  counter_chain_ctrl dut (
    .clk(clk), .Reset(Reset), .start(start), .stop(stop), .pause(pause), .step(step),
    .load(load), .load_n(load_n), .load_m(load_m), .target_n(target_n), .target_m(target_m),
    .count_n(count_n), .count_m(count_m), .carry_n(carry_n), .carry_m(carry_m),
    .busy(busy), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_b, start, stop, pause, step, load, glitch;
    logic [2:0]  ln;
    logic [3:0]  lm;
    logic [12:0] exp;
  } stim_t;

  // {state, count_n, count_m, carry_n, carry_m, busy, done}
  logic [12:0] obs;
  assign obs = {state, count_n, count_m, carry_n, carry_m, busy, done};

  logic [12:0] sbq[$];
  stim_t       plan[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [12:0] e;

  function automatic logic [12:0] ev(int s, int n, int m, bit cn, bit cm);
    logic [1:0] s2;
    logic [2:0] n3;
    logic [3:0] m4;
    s2 = s[1:0];
    n3 = n[2:0];
    m4 = m[3:0];
    return {s2, n3, m4, cn, cm, (s2 == 2'b01) || (s2 == 2'b10), s2 == 2'b11};
  endfunction

  // args: rst_b start stop pause step load ln lm glitch
  function automatic stim_t mk(bit r, bit st, bit sp, bit pa, bit stp, bit ld, int ln, int lm, bit gl);
    stim_t s;
    s.rst_b = r;  s.start = st; s.stop = sp; s.pause = pa; s.step = stp; s.load = ld;
    s.glitch = gl; s.ln = ln[2:0]; s.lm = lm[3:0]; s.exp = '0;
    return s;
  endfunction

  function void add(stim_t s, logic [12:0] x);
    s.exp = x;
    plan.push_back(s);
  endfunction

  stim_t NOP, START, STOP, PAUSE_I, STEP_I;
  initial begin
    NOP     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    START   = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    STOP    = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);
    PAUSE_I = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    STEP_I  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);
  end

  task automatic drive(stim_t s);
    Reset = s.rst_b; start = s.start; stop = s.stop; pause = s.pause;
    step = s.step; load = s.load; load_n = s.ln; load_m = s.lm;
    sbq.push_back(s.exp);
    if (s.glitch) begin
      Reset = 1'b0;
      #2;
      Reset = 1'b1;
    end
  endtask

  task automatic test_reset();
    plan.delete();
    for (int i = 0; i < 3; i++) add(mk(0, 1, 0, 0, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0));
    add(mk(1, 1, 1, 0, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); @(posedge clk); #1;
      e = sbq.pop_front(); vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: st|n|m|cn|cm|busy|done got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_run_carry();
    target_n = 3'd7; target_m = 4'd15;
    plan.delete();
    add(START, ev(1, 0, 0, 0, 0));
    for (int k = 1; k <= 6; k++) add(NOP, ev(1, k % 6, k / 6, (k % 6) == 0, 0));
    add(STOP, ev(0, 0, 1, 0, 0));
    add(mk(1, 0, 0, 0, 0, 1, 0, 0, 0), ev(0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); @(posedge clk); #1;
      e = sbq.pop_front(); vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL run_carry[%0d]: st|n|m|cn|cm|busy|done got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    target_n = 3'd0; target_m = 4'd15;
    plan.delete();
    add(mk(1, 1, 0, 0, 0, 1, 0, 0, 0), ev(1, 0, 0, 0, 0));
    for (int k = 1; k <= 78; k++)
      add(NOP, ev(1, k % 6, (k / 6) % 13, (k % 6) == 0, (k % 78) == 0));
    add(STOP, ev(0, 0, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); @(posedge clk); #1;
      e = sbq.pop_front(); vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL out_of_range[%0d]: st|n|m|cn|cm|busy|done got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_target();
    target_n = 3'd2; target_m = 4'd3;
    plan.delete();
    add(START, ev(1, 0, 0, 0, 0));
    for (int k = 1; k < 20; k++) add(NOP, ev(1, k % 6, k / 6, (k % 6) == 0, 0));
    add(NOP, ev(3, 2, 3, 0, 0));
    add(START & 0 | NOP, ev(3, 2, 3, 0, 0));
    add(PAUSE_I, ev(3, 2, 3, 0, 0));
    add(STOP, ev(0, 2, 3, 0, 0));
    // second pass: restart from DONE clears the counts
    add(mk(1, 1, 0, 0, 0, 1, 0, 0, 0), ev(1, 0, 0, 0, 0));
    for (int k = 1; k < 20; k++) add(NOP, ev(1, k % 6, k / 6, (k % 6) == 0, 0));
    add(NOP, ev(3, 2, 3, 0, 0));
    add(START, ev(1, 0, 0, 0, 0));
    add(NOP, ev(1, 1, 0, 0, 0));
    add(STOP, ev(0, 1, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); @(posedge clk); #1;
      e = sbq.pop_front(); vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL target[%0d]: st|n|m|cn|cm|busy|done got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_pause_step();
    target_n = 3'd7; target_m = 4'd15;
    plan.delete();
    add(mk(1, 0, 0, 0, 0, 1, 0, 0, 0), ev(0, 0, 0, 0, 0));
    add(START, ev(1, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) add(NOP, ev(1, k, 0, 0, 0));
    add(PAUSE_I, ev(2, 4, 0, 0, 0));
    add(STEP_I, ev(2, 5, 0, 0, 0));
    add(STEP_I, ev(2, 0, 1, 1, 0));
    add(STEP_I, ev(2, 1, 1, 0, 0));
    add(NOP, ev(2, 1, 1, 0, 0));
    add(START, ev(1, 1, 1, 0, 0));
    add(NOP, ev(1, 2, 1, 0, 0));
    add(PAUSE_I, ev(2, 2, 1, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); @(posedge clk); #1;
      e = sbq.pop_front(); vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL pause_step[%0d]: st|n|m|cn|cm|busy|done got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_load();
    plan.delete();
    // load_n is only 3 bits wide, so 7 is the largest out-of-range digit-N value
    add(mk(1, 0, 0, 0, 0, 1, 7, 12, 0), ev(2, 0, 12, 0, 0));
    add(START, ev(1, 0, 12, 0, 0));
    for (int k = 1; k <= 6; k++)
      add(NOP, ev(1, k % 6, (k == 6) ? 0 : 12, k == 6, k == 6));
    add(mk(1, 0, 0, 0, 0, 1, 3, 3, 0), ev(1, 1, 0, 0, 0));
    add(STOP, ev(0, 1, 0, 0, 0));
    add(mk(1, 0, 0, 0, 0, 1, 3, 14, 0), ev(0, 3, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); @(posedge clk); #1;
      e = sbq.pop_front(); vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL load[%0d]: st|n|m|cn|cm|busy|done got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_step_match();
    target_n = 3'd2; target_m = 4'd0;
    plan.delete();
    add(mk(1, 1, 0, 0, 0, 1, 0, 0, 0), ev(1, 0, 0, 0, 0));
    add(PAUSE_I, ev(2, 0, 0, 0, 0));
    add(STEP_I, ev(2, 1, 0, 0, 0));
    add(STEP_I, ev(3, 2, 0, 0, 0));
    add(mk(1, 0, 0, 0, 0, 1, 4, 5, 0), ev(0, 4, 5, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); @(posedge clk); #1;
      e = sbq.pop_front(); vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL step_match[%0d]: st|n|m|cn|cm|busy|done got %b required %b", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    target_n = 3'd7; target_m = 4'd15;
    plan.delete();
    add(START, ev(1, 4, 5, 0, 0));
    add(NOP, ev(1, 5, 5, 0, 0));
    add(NOP, ev(1, 0, 6, 1, 0));
    add(mk(0, 1, 0, 0, 0, 0, 0, 0, 0), ev(0, 0, 0, 0, 0));
    add(START, ev(1, 0, 0, 0, 0));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 1), ev(1, 1, 0, 0, 0));
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 1), ev(1, 2, 0, 0, 0));
    add(STOP, ev(0, 2, 0, 0, 0));
    foreach (plan[i]) begin
      drive(plan[i]); @(posedge clk); #1;
      e = sbq.pop_front(); vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_mid_run[%0d]: st|n|m|cn|cm|busy|done got %b required %b", i, obs, e);
      end
    end
  endtask

  initial begin
    Reset = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0; step = 1'b0; load = 1'b0;
    load_n = '0; load_m = '0; target_n = 3'd7; target_m = 4'd15;
    test_reset();
    test_run_carry();
    test_out_of_range();
    test_target();
    test_pause_step();
    test_load();
    test_step_match();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
